// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch constants, opcode values and fetch state type.
package if_stage_pkg;
   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
   localparam logic [31:0] PC_INC      = 32'd4;
   localparam logic [6:0]  OP_R        = 7'b0110011;
   localparam logic [6:0]  OP_I_ALU    = 7'b0010011;
   localparam logic [6:0]  OP_LUI      = 7'b0110111;
   localparam logic [6:0]  OP_LOAD     = 7'b0000011;
   localparam logic [6:0]  OP_STORE    = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
   localparam logic [6:0]  OP_JAL      = 7'b1101111;
   typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/if_stage_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and flush-to-bubble controls.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] fetch_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        valid
);
   // flush wins over hold so a redirect squashes the slot even while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         instr <= NOP_INSTR;
         pc    <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!hold) begin
         instr <= fetch_instr;
         pc    <= fetch_pc;
         valid <= 1'b1;
      end
   end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC sequencing, redirect/stall handling, misaligned-target fault
// and fetch counting in front of the IF/ID register.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] Target,
   output logic [31:0] IMemAddr,
   input  logic [31:0] IMemData,
   output logic [31:0] Instr,
   output logic [31:0] PC_ID,
   output logic        Valid_ID,
   output logic        Fault,
   output logic [31:0] FetchCnt
);
   fetch_state_t state, state_next;
   logic [31:0] pc, pc_next;
   logic hold, flush, fetch;
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= RUN;
         pc       <= RESET_PC;
         FetchCnt <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         FetchCnt <= fetch ? FetchCnt + 32'd1 : FetchCnt;
      end
   end
   // HALT freezes the PC and keeps a bubble in IF/ID until reset
   always_comb begin
      state_next = state;
      pc_next    = pc;
      hold       = 1'b0;
      flush      = 1'b0;
      fetch      = 1'b0;
      if (state == HALT) flush = 1'b1;
      else if (Redirect) begin
         flush = 1'b1;
         if (Target[1:0] == 2'b00) pc_next = Target;
         else state_next = HALT;
      end else if (Stall) hold = 1'b1;
      else begin
         pc_next = pc + PC_INC;
         fetch   = 1'b1;
      end
   end
   assign IMemAddr = pc;
   assign Fault    = (state == HALT);
   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clk         (Clk),
      .rst         (Reset),
      .hold        (hold),
      .flush       (flush),
      .fetch_instr (IMemData),
      .fetch_pc    (pc),
      .instr       (Instr),
      .pc          (PC_ID),
      .valid       (Valid_ID)
   );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus hand-written redirect latency check.
module tb_if_stage;
   logic        Clk = 1'b0;
   logic        Reset, Stall, Redirect;
   logic [31:0] Target, IMemAddr, IMemData, Instr, PC_ID, FetchCnt;
   logic        Valid_ID, Fault;
   int          n_chk = 0;
   int          n_fail = 0;
   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] target, addr, instr, pc_id;
      logic        valid, fault;
      logic [31:0] cnt;
   } vec_t;
   vec_t vt [0:23];
   always #5 Clk = ~Clk;
   // memory word[i] = i
   assign IMemData = {2'b00, IMemAddr[31:2]};
   if_stage dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .Target(Target),
      .IMemAddr(IMemAddr), .IMemData(IMemData), .Instr(Instr), .PC_ID(PC_ID),
      .Valid_ID(Valid_ID), .Fault(Fault), .FetchCnt(FetchCnt)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
      @(negedge Clk);
      Reset = r; Stall = s; Redirect = d; Target = t;
      @(posedge Clk);
      #1;
   endtask
   initial begin
      Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Target = '0;
      //            rst stall redir target        addr          instr         pc_id         v  f  cnt
      vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h13,       32'h0,        1'b0, 1'b0, 32'd0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h13,       32'h0,        1'b0, 1'b0, 32'd0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 1'b0, 32'd1};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1,        32'h4,        1'b1, 1'b0, 32'd2};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h1,        32'h4,        1'b1, 1'b0, 32'd2};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h1,        32'h4,        1'b1, 1'b0, 32'd2};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h2,        32'h8,        1'b1, 1'b0, 32'd3};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 32'h40,       32'h40,       32'h13,       32'h8,        1'b0, 1'b0, 32'd3};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h10,       32'h40,       1'b1, 1'b0, 32'd4};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h13,       32'h40,       1'b0, 1'b0, 32'd4};
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3FFFFFFF, 32'hFFFFFFFC, 1'b1, 1'b0, 32'd5};
      vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 1'b0, 32'd6};
      vt[12] = '{1'b0, 1'b0, 1'b1, 32'h42,       32'h4,        32'h13,       32'h0,        1'b0, 1'b1, 32'd6};
      vt[13] = '{1'b0, 1'b0, 1'b1, 32'h80,       32'h4,        32'h13,       32'h0,        1'b0, 1'b1, 32'd6};
      vt[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h4,        32'h13,       32'h0,        1'b0, 1'b1, 32'd6};
      vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h13,       32'h0,        1'b0, 1'b1, 32'd6};
      vt[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h13,       32'h0,        1'b0, 1'b0, 32'd0};
      vt[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 1'b0, 32'd1};
      vt[18] = '{1'b0, 1'b0, 1'b1, 32'h100,      32'h100,      32'h13,       32'h0,        1'b0, 1'b0, 32'd1};
      vt[19] = '{1'b1, 1'b0, 1'b1, 32'h200,      32'h0,        32'h13,       32'h0,        1'b0, 1'b0, 32'd0};
      vt[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 1'b0, 32'd1};
      vt[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 1'b0, 32'd1};
      vt[22] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h13,       32'h0,        1'b0, 1'b0, 32'd0};
      vt[23] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 1'b0, 32'd1};
      for (int i = 0; i < 24; i++) begin
         step(vt[i].rst, vt[i].stall, vt[i].redir, vt[i].target);
         chk($sformatf("v%0d addr", i), IMemAddr, vt[i].addr);
         chk($sformatf("v%0d instr", i), Instr, vt[i].instr);
         chk($sformatf("v%0d pc_id", i), PC_ID, vt[i].pc_id);
         chk($sformatf("v%0d valid", i), {31'd0, Valid_ID}, {31'd0, vt[i].valid});
         chk($sformatf("v%0d fault", i), {31'd0, Fault}, {31'd0, vt[i].fault});
         chk($sformatf("v%0d cnt", i), FetchCnt, vt[i].cnt);
      end
      // redirect latency: address moves after one edge, target word lands on Instr after two
      step(1'b0, 1'b0, 1'b1, 32'h20);
      chk("lat addr1", IMemAddr, 32'h20);
      chk("lat valid1", {31'd0, Valid_ID}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("lat instr2", Instr, 32'h8);
      chk("lat pc_id2", PC_ID, 32'h20);
      chk("lat addr2", IMemAddr, 32'h24);
      chk("lat cnt2", FetchCnt, 32'd2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
